// File: rtl/set_job_dispatcher_if.sv
// Handshake bundle for set_job_dispatcher: byte stream in, SET job/result
// channel, and the per-job result strobe.
interface set_job_dispatcher_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        set_en;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;
    logic        set_busy;
    logic        set_valid;
    logic [7:0]  set_candidate;
    logic        res_valid;
    logic [7:0]  res_count;
    logic [1:0]  res_mode;
    logic        res_err;
    logic [15:0] jobs_done;

    modport master (
        input  in_valid, in_data, set_busy, set_valid, set_candidate,
        output in_ready, set_en, set_central, set_radius, set_mode,
               res_valid, res_count, res_mode, res_err, jobs_done
    );

    modport slave (
        output in_valid, in_data, set_busy, set_valid, set_candidate,
        input  in_ready, set_en, set_central, set_radius, set_mode,
               res_valid, res_count, res_mode, res_err, jobs_done
    );
endinterface

// File: rtl/set_job_dispatcher.sv
// Packs 6-byte packets into SET jobs, queues them, and runs one job at a time
// against the SET engine, reporting each count (or a timeout) in order.
module set_job_dispatcher #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 127
) (
    input  logic                 clk,
    input  logic                 rst,
    set_job_dispatcher_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int JW = 38;
    localparam logic [CW-1:0] ONE_C     = {{PW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] FULL_C    = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PONE_C    = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [6:0]    TIMEOUT_C = 7'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    logic [2:0]    byte_idx_r;
    logic [1:0]    mode_asm_r;
    logic [23:0]   central_asm_r;
    logic [3:0]    rad_hi_r;
    logic [JW-1:0] fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          ready_r;
    state_t        state_r;
    logic [6:0]    timer_r;
    logic [6:0]    timer_inc_s;
    logic          timeout_s;
    logic          accept_s;
    logic          push_s;
    logic          pop_s;
    logic          set_en_r;
    logic [23:0]   set_central_r;
    logic [11:0]   set_radius_r;
    logic [1:0]    set_mode_r;
    logic          res_valid_r;
    logic [7:0]    res_count_r;
    logic [1:0]    res_mode_r;
    logic          res_err_r;
    logic [15:0]   jobs_done_r;

    assign accept_s    = bus.in_valid && ready_r;
    assign push_s      = accept_s && (byte_idx_r == 3'd5);
    assign pop_s       = (state_r == ST_IDLE) && (count_r != {CW{1'b0}}) && !bus.set_busy;
    // Timer value after this cycle; hitting TIMEOUT here makes the abort land
    // exactly TIMEOUT cycles after set_en rose.
    assign timer_inc_s = timer_r + 7'd1;
    assign timeout_s   = (timer_inc_s == TIMEOUT_C);

    // Next FIFO occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + ONE_C;
            2'b01:   count_next_s = count_r - ONE_C;
            default: count_next_s = count_r;
        endcase
    end

    // Byte assembler: collects mode, centres and radius-high ahead of the last byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx_r    <= 3'd0;
            mode_asm_r    <= 2'd0;
            central_asm_r <= 24'd0;
            rad_hi_r      <= 4'd0;
        end else if (accept_s) begin
            case (byte_idx_r)
                3'd0:    mode_asm_r            <= bus.in_data[1:0];
                3'd1:    central_asm_r[23:16]  <= bus.in_data;
                3'd2:    central_asm_r[15:8]   <= bus.in_data;
                3'd3:    central_asm_r[7:0]    <= bus.in_data;
                3'd4:    rad_hi_r              <= bus.in_data[3:0];
                default: rad_hi_r              <= rad_hi_r;
            endcase
            byte_idx_r <= (byte_idx_r == 3'd5) ? 3'd0 : byte_idx_r + 3'd1;
        end else begin
            byte_idx_r <= byte_idx_r;
        end
    end

    // Job FIFO storage, pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {JW{1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            ready_r  <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {mode_asm_r, central_asm_r, rad_hi_r, bus.in_data};
                wr_ptr_r             <= wr_ptr_r + PONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PONE_C;
            end
            count_r <= count_next_s;
            ready_r <= (count_next_s != FULL_C);
        end
    end

    // Dispatcher FSM: issue, wait for SET to go busy, then collect or time out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            timer_r       <= 7'd0;
            set_en_r      <= 1'b0;
            set_central_r <= 24'd0;
            set_radius_r  <= 12'd0;
            set_mode_r    <= 2'd0;
            res_valid_r   <= 1'b0;
            res_count_r   <= 8'd0;
            res_mode_r    <= 2'd0;
            res_err_r     <= 1'b0;
            jobs_done_r   <= 16'd0;
        end else begin
            set_en_r    <= 1'b0;
            res_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        {set_mode_r, set_central_r, set_radius_r} <= fifo_mem_r[rd_ptr_r];
                        set_en_r <= 1'b1;
                        timer_r  <= 7'd0;
                        state_r  <= ST_ISSUE;
                    end
                end
                ST_ISSUE, ST_RUN: begin
                    // In ISSUE a held set_valid belongs to the previous job.
                    if ((state_r == ST_RUN) && bus.set_valid && !bus.set_busy) begin
                        res_count_r <= bus.set_candidate;
                        res_mode_r  <= set_mode_r;
                        res_err_r   <= 1'b0;
                        res_valid_r <= 1'b1;
                        jobs_done_r <= jobs_done_r + 16'd1;
                        state_r     <= ST_IDLE;
                    end else if (timeout_s) begin
                        res_count_r <= 8'd0;
                        res_mode_r  <= set_mode_r;
                        res_err_r   <= 1'b1;
                        res_valid_r <= 1'b1;
                        jobs_done_r <= jobs_done_r + 16'd1;
                        state_r     <= ST_IDLE;
                    end else begin
                        timer_r <= timer_inc_s;
                        if (bus.set_busy) begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready    = ready_r;
    assign bus.set_en      = set_en_r;
    assign bus.set_central = set_central_r;
    assign bus.set_radius  = set_radius_r;
    assign bus.set_mode    = set_mode_r;
    assign bus.res_valid   = res_valid_r;
    assign bus.res_count   = res_count_r;
    assign bus.res_mode    = res_mode_r;
    assign bus.res_err     = res_err_r;
    assign bus.jobs_done   = jobs_done_r;
endmodule

// File: tb/tb_set_job_dispatcher.sv
// Directed bench for set_job_dispatcher with a behavioural SET stub and an
// in-order result scoreboard.
module tb_set_job_dispatcher;
    typedef struct packed {
        logic [1:0]  mode;
        logic [23:0] central;
        logic [11:0] radius;
        logic [7:0]  count;
        logic        err;
    } exp_t;

    logic clk;
    logic rst;
    set_job_dispatcher_if bus ();

    set_job_dispatcher #(.FIFO_DEPTH(4), .TIMEOUT(127)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb_q[$];
    int          lat_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          en_cyc = 0;
    logic [15:0] exp_done;

    int          stub_dly;
    int          stub_len;
    bit          stub_ignore;
    bit          stub_keep_stale;
    bit          stub_fixed;
    logic [7:0]  stub_fixed_cand;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] cand_rule(logic [23:0] c, logic [11:0] r, logic [1:0] m);
        return c[15:8] ^ r[7:0] ^ {6'b0, m};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SET stub: optional delay, busy for stub_len cycles, then a held valid.
    initial begin
        int         sp;
        int         scnt;
        logic [7:0] s_cand;
        sp = 0; scnt = 0; s_cand = 8'd0;
        bus.set_busy = 1'b0; bus.set_valid = 1'b0; bus.set_candidate = 8'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sp = 0;
                bus.set_busy = 1'b0; bus.set_valid = 1'b0; bus.set_candidate = 8'd0;
            end else begin
                case (sp)
                    0: if (bus.set_en) begin
                        s_cand = stub_fixed ? stub_fixed_cand
                                            : cand_rule(bus.set_central, bus.set_radius, bus.set_mode);
                        if (!stub_keep_stale) bus.set_valid = 1'b0;
                        if (stub_ignore) sp = 0;
                        else if (stub_dly == 0) begin
                            bus.set_busy = 1'b1; bus.set_valid = 1'b0; scnt = stub_len; sp = 2;
                        end else begin
                            scnt = stub_dly - 1; sp = 1;
                        end
                    end
                    1: if (scnt == 0) begin
                        bus.set_busy = 1'b1; bus.set_valid = 1'b0; scnt = stub_len; sp = 2;
                    end else scnt--;
                    2: if (scnt == 1) begin
                        bus.set_busy = 1'b0; bus.set_valid = 1'b1; bus.set_candidate = s_cand; sp = 0;
                    end else scnt--;
                    default: sp = 0;
                endcase
            end
        end
    end

    // Monitor: en pulse width, latency log, and scoreboard compare on res_valid.
    initial begin
        bit   prev_en;
        exp_t e;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                prev_en = 1'b0;
            end else begin
                if (prev_en) check("en_one_cycle", 64'(bus.set_en), 64'(0));
                if (bus.set_en) en_cyc = cyc;
                prev_en = bus.set_en;
                if (bus.res_valid) begin
                    lat_q.push_back(cyc - en_cyc);
                    if (sb_q.size() == 0) begin
                        checks++; errors++;
                        $error("FAIL unexpected_res: observed res_valid=1 expected none, count=%0h", bus.res_count);
                    end else begin
                        e = sb_q.pop_front();
                        exp_done = exp_done + 16'd1;
                        check("res_count",   64'(bus.res_count),   64'(e.count));
                        check("res_mode",    64'(bus.res_mode),    64'(e.mode));
                        check("res_err",     64'(bus.res_err),     64'(e.err));
                        check("jobs_done",   64'(bus.jobs_done),   64'(exp_done));
                        check("set_central", 64'(bus.set_central), 64'(e.central));
                        check("set_radius",  64'(bus.set_radius),  64'(e.radius));
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int t = 0; t < 1000; t++) begin
            if (bus.in_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        else begin
            checks++; errors++;
            $error("FAIL byte_accept_timeout: observed in_ready=0 expected 1 within budget");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_job(input logic [1:0] m, input logic [23:0] c, input logic [11:0] r,
                            input bit ign, input logic [3:0] junk);
        exp_t e;
        e.mode = m; e.central = c; e.radius = r; e.err = ign;
        e.count = ign ? 8'd0 : (stub_fixed ? stub_fixed_cand : cand_rule(c, r, m));
        sb_q.push_back(e);
        send_byte({junk, junk[1:0], m});
        send_byte(c[23:16]);
        send_byte(c[15:8]);
        send_byte(c[7:0]);
        send_byte({junk, r[11:8]});
        send_byte(r[7:0]);
    endtask

    task automatic wait_en(input int budget);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < budget; t++) begin
            if (bus.set_en === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("set_en_seen", 64'(seen), 64'(1));
    endtask

    task automatic wait_drain(input int budget);
        bit done;
        done = 1'b0;
        for (int t = 0; t < budget; t++) begin
            if (sb_q.size() == 0) begin done = 1'b1; break; end
            @(negedge clk);
        end
        check("drain_pending", 64'(sb_q.size()), 64'(0));
        if (done) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 8'd0;
        stub_dly = 0; stub_len = 10; stub_ignore = 1'b0; stub_keep_stale = 1'b0;
        stub_fixed = 1'b0; stub_fixed_cand = 8'd0;
        exp_done = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",  64'(bus.in_ready),  64'(0));
        check("rst_set_en",    64'(bus.set_en),    64'(0));
        check("rst_res_valid", 64'(bus.res_valid), 64'(0));
        check("rst_jobs_done", 64'(bus.jobs_done), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 64'(bus.in_ready), 64'(1));

        // Basic job with fixed candidate 17 and 64 busy cycles
        stub_len = 64; stub_fixed = 1'b1; stub_fixed_cand = 8'd17;
        lat_q.delete();
        send_job(2'd1, 24'h446600, 12'h320, 1'b0, 4'h0);
        wait_en(20);
        check("t1_central", 64'(bus.set_central), 64'(24'h446600));
        check("t1_radius",  64'(bus.set_radius),  64'(12'h320));
        check("t1_mode",    64'(bus.set_mode),    64'(2'd1));
        wait_drain(300);
        check("t1_latency", 64'(lat_q[0]), 64'(65));
        stub_fixed = 1'b0;

        // Back-to-back packets fill the FIFO behind a running job
        stub_len = 60;
        lat_q.delete();
        for (int i = 0; i < 5; i++)
            send_job(2'(i), 24'h123456 + 24'(i) * 24'h010203, 12'h0A0 + 12'(i), 1'b0, 4'(i * 5));
        check("t2_full_stall", 64'(bus.in_ready), 64'(0));
        send_job(2'd3, 24'hABCDEF, 12'hFED, 1'b0, 4'hF);
        wait_drain(3000);
        check("t2_results", 64'(lat_q.size()), 64'(6));
        check("t2_lat_last", 64'(lat_q[5]), 64'(61));

        // Stale held valid must not complete a job before busy is seen
        stub_keep_stale = 1'b1; stub_dly = 2; stub_len = 10;
        lat_q.delete();
        send_job(2'd2, 24'h00F000, 12'h001, 1'b0, 4'h0);
        wait_en(20);
        @(negedge clk);
        stub_keep_stale = 1'b0; stub_dly = 0;
        wait_drain(200);
        check("t3_latency", 64'(lat_q[0]), 64'(13));

        // SET never goes busy: timeout, then the queued job proceeds
        stub_ignore = 1'b1;
        lat_q.delete();
        send_job(2'd3, 24'h777777, 12'h777, 1'b1, 4'h0);
        wait_en(20);
        @(negedge clk);
        stub_ignore = 1'b0;
        send_job(2'd1, 24'h010203, 12'h456, 1'b0, 4'h0);
        wait_drain(600);
        check("t4_timeout_lat", 64'(lat_q[0]), 64'(127));
        check("t4_next_lat",    64'(lat_q[1]), 64'(11));

        // Reset mid-RUN with a partial packet pending
        stub_len = 100;
        send_job(2'd2, 24'h222222, 12'h222, 1'b0, 4'h0);
        send_byte(8'h01); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("r_set_en",    64'(bus.set_en),      64'(0));
        check("r_central",   64'(bus.set_central), 64'(0));
        check("r_radius",    64'(bus.set_radius),  64'(0));
        check("r_mode",      64'(bus.set_mode),    64'(0));
        check("r_res_count", 64'(bus.res_count),   64'(0));
        check("r_res_mode",  64'(bus.res_mode),    64'(0));
        check("r_res_err",   64'(bus.res_err),     64'(0));
        check("r_jobs_done", 64'(bus.jobs_done),   64'(0));
        check("r_in_ready",  64'(bus.in_ready),    64'(0));
        sb_q.delete();
        exp_done = 16'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        stub_len = 5;
        lat_q.delete();
        send_job(2'd1, 24'h5A5A5A, 12'hA5A, 1'b0, 4'h0);
        wait_drain(200);
        check("t5_jobs_done", 64'(bus.jobs_done), 64'(1));
        check("t5_latency",   64'(lat_q[0]),      64'(6));

        // Completed-job counter wraps from 0xFFFF to 0
        force dut.jobs_done_r = 16'hFFFF;
        #1;
        release dut.jobs_done_r;
        exp_done = 16'hFFFF;
        send_job(2'd0, 24'h0F0F0F, 12'h0F0, 1'b0, 4'h0);
        wait_drain(200);
        check("t6_wrap", 64'(bus.jobs_done), 64'(16'h0000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
